// File: rtl/cic_comp_pkg.sv
// Shared constants and types for the CIC compensation FIR.
package cic_comp_pkg;

    localparam int NTAPS     = 7;
    localparam int SHIFT     = 5;
    localparam int ACC_EXTRA = 8;   // accumulator is DW + ACC_EXTRA bits
    localparam int COEF_W    = 6;
    localparam int IDX_W     = 3;

    // Symmetric taps, sum = 32 = 2**SHIFT, so DC gain is 1 after the shift.
    localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
        -6'sd1, 6'sd0, 6'sd9, 6'sd16, 6'sd9, 6'sd0, -6'sd1
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } fir_state_t;

    // Coefficient lookup that returns zero past the last tap.
    function automatic logic signed [COEF_W-1:0] coef_at(input logic [IDX_W-1:0] i);
        if (i < IDX_W'(NTAPS)) begin
            return COEF[i];
        end
        return '0;
    endfunction

endpackage

// File: rtl/cic_comp_rndsat.sv
// Round-half-up arithmetic shift by SHIFT, then clamp to the signed DW range.
module cic_comp_rndsat
    import cic_comp_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic signed [DW+ACC_EXTRA-1:0] acc,
    output logic signed [DW-1:0]           dout
);

    localparam int AW = DW + ACC_EXTRA;
    localparam int BW = AW + 1;       // one guard bit so the rounding add cannot wrap
    localparam int SW = BW - SHIFT;

    localparam logic signed [BW-1:0] HALF    = BW'(2 ** (SHIFT - 1));
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    logic signed [BW-1:0] biased;
    logic signed [SW-1:0] shifted;

    // Add half an LSB, drop SHIFT bits (floor), then saturate.
    always_comb begin
        biased  = BW'(acc) + HALF;
        shifted = biased[BW-1:SHIFT];
        if (shifted > SAT_MAX) begin
            dout = SAT_MAX[DW-1:0];
        end else if (shifted < SAT_MIN) begin
            dout = SAT_MIN[DW-1:0];
        end else begin
            dout = shifted[DW-1:0];
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// 7-tap symmetric compensation FIR behind the CIC decimator.
// One serial MAC per tap: accept in IDLE, seven MAC cycles, one ROUND cycle.
//
// Handshake: in_valid is a one-cycle strobe with no back-pressure. A strobe
// seen in IDLE is accepted on that edge; a strobe seen while busy is dropped,
// leaves the delay line and accumulator untouched, and sets the sticky
// overrun flag. out_valid is a one-cycle strobe; data_out holds between
// strobes.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] data_in,
    input  logic                 ovr_clr,
    output logic signed [DW-1:0] data_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun,
    output fir_state_t           state_dbg
);

    localparam int ACC_W = DW + ACC_EXTRA;

    fir_state_t state_q;
    fir_state_t state_d;

    logic signed [DW-1:0]     tap_q [NTAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]         idx_q;

    logic                     accept;
    logic                     drop;
    logic signed [DW-1:0]     tap_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [ACC_W-1:0]  mac_term;
    logic signed [DW-1:0]     rnd_out;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus accept/drop qualification of the input strobe.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                drop = in_valid;
                if (idx_q == IDX_W'(NTAPS - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                drop    = in_valid;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the current tap and coefficient and form the product at full accumulator width.
    always_comb begin
        tap_sel  = '0;
        coef_sel = coef_at(idx_q);
        if (idx_q < IDX_W'(NTAPS)) begin
            tap_sel = tap_q[idx_q];
        end
        mac_term = ACC_W'(tap_sel) * ACC_W'(coef_sel);
    end

    // Delay line, accumulator and tap index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_q[k] <= '0;
            end
            acc_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                tap_q[k] <= tap_q[k-1];
            end
            tap_q[0] <= data_in;
            acc_q    <= '0;
            idx_q    <= '0;
        end else if (state_q == MAC) begin
            acc_q <= acc_q + mac_term;
            idx_q <= idx_q + 1'b1;
        end
    end

    cic_comp_rndsat #(
        .DW (DW)
    ) u_rndsat (
        .acc  (acc_q),
        .dout (rnd_out)
    );

    // Output register: capture the rounded result in ROUND, pulse out_valid once.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_q == ROUND);
            if (state_q == ROUND) begin
                data_out <= rnd_out;
            end
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: directed scenarios plus randomized traffic against a
// sample-history model of the filter.
module tb_cic_comp_fir;

    localparam int DW = 16;
    localparam int SPACING = 9;
    localparam int LATENCY = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] data_in = '0;
    logic                 ovr_clr = 1'b0;
    logic signed [DW-1:0] data_out;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;
    cic_comp_pkg::fir_state_t state_dbg;

    cic_comp_fir #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .ovr_clr   (ovr_clr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    int cm [7] = '{-1, 0, 9, 16, 9, 0, -1};
    int hist [7];
    int since = SPACING;
    bit m_ovr = 1'b0;
    int edge_n = 0;

    logic signed [DW-1:0] exp_q[$];
    int                   exp_cyc_q[$];
    logic signed [DW-1:0] got_q[$];
    logic signed [DW-1:0] last_out = '0;
    logic                 exp_v;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Filter output from the sample history: sum c[k]*x[n-k], floor((s+16)/32), clamp.
    function automatic int ref_out();
        longint s = 0;
        longint b;
        longint q;
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        for (int k = 0; k < 7; k++) s += longint'(cm[k]) * longint'(hist[k]);
        b = s + 16;
        q = b / 32;
        if (b < 0 && (b % 32) != 0) q = q - 1;
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit v, input int d, input bit clr, input bit rst);
        bit drop;
        reset    = rst;
        in_valid = v;
        data_in  = DW'(d);
        ovr_clr  = clr;
        @(posedge clk);
        edge_n++;
        drop = 1'b0;
        if (rst) begin
            for (int k = 0; k < 7; k++) hist[k] = 0;
            since    = SPACING;
            m_ovr    = 1'b0;
            last_out = '0;
            exp_q.delete();
            exp_cyc_q.delete();
        end else begin
            if (v) begin
                if (since >= SPACING) begin
                    for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
                    hist[0] = int'(data_in);
                    exp_q.push_back(DW'(ref_out()));
                    exp_cyc_q.push_back(edge_n + LATENCY);
                    since = 0;
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
            if (since < SPACING) since++;
        end
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic send(input int d);
        drive(1'b1, d, 1'b0, 1'b0);
        idle(SPACING - 1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(($urandom_range(0, 1) == 1), 1234, 1'b0, 1'b1);
    endtask

    task automatic impulse_check(input string tag);
        int imp_exp [8] = '{-31, 0, 281, 500, 281, 0, -31, 0};
        got_q.delete();
        send(1000);
        for (int i = 0; i < 7; i++) send(0);
        idle(1);
        check({tag, "_count"}, got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check($sformatf("%s_%0d", tag, i), got_q[i], imp_exp[i]);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (edge_n > 0) begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < edge_n) begin
                void'(exp_cyc_q.pop_front());
                void'(exp_q.pop_front());
            end
            exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == edge_n);
            if (exp_v || out_valid) begin
                check("out_valid", out_valid, exp_v);
                if (out_valid) got_q.push_back(data_out);
                if (exp_v) begin
                    check("data_out", data_out, exp_q[0]);
                    last_out = exp_q[0];
                    void'(exp_cyc_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end else begin
                check("hold", data_out, last_out);
            end
            check("busy", busy, (since < SPACING));
            check("overrun", overrun, m_ovr);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset(3);
        check("rst_data", data_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);

        // Impulse response.
        impulse_check("impulse");

        // DC gain of one.
        do_reset(1);
        got_q.delete();
        for (int i = 0; i < 10; i++) send(1000);
        idle(1);
        check("dc_count", got_q.size(), 10);
        for (int i = 6; i < got_q.size(); i++) check($sformatf("dc_%0d", i), got_q[i], 1000);

        // Positive saturation.
        do_reset(1);
        got_q.delete();
        send(-32768);
        for (int i = 0; i < 5; i++) send(32767);
        send(-32768);
        idle(1);
        check("sat_count", got_q.size(), 7);
        if (got_q.size() == 7) check("sat_out", got_q[6], 32767);

        // Overrun: accept at E0, drop at E3, clear at E10.
        do_reset(1);
        got_q.delete();
        drive(1'b1, 500, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 700, 1'b0, 1'b0);
        idle(1);
        check("ovr_set", overrun, 1);
        idle(5);
        drive(1'b0, 0, 1'b1, 1'b0);
        check("ovr_clr", overrun, 0);
        idle(1);
        check("ovr_count", got_q.size(), 1);

        // Reset in the middle of a computation.
        do_reset(1);
        got_q.delete();
        drive(1'b1, 1234, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 0, 1'b0, 1'b1);
        idle(12);
        check("abort_count", got_q.size(), 0);
        check("abort_data", data_out, 0);
        check("abort_busy", busy, 0);
        impulse_check("impulse2");

        // Back-to-back at minimum spacing.
        do_reset(1);
        got_q.delete();
        for (int i = 0; i < 100; i++) send(int'($urandom_range(0, 65535)) - 32768);
        idle(1);
        check("b2b_count", got_q.size(), 100);
        check("b2b_ovr", overrun, 0);

        // Random spacing, random clears, random reset pulses.
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0);
            for (int j = 0; j < int'($urandom_range(0, 12)); j++)
                drive(1'b0, 0, ($urandom_range(0, 7) == 0), 1'b0);
            if ($urandom_range(0, 49) == 0) do_reset(1);
        end
        idle(SPACING + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed sample width of data_in and data_out.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  one-cycle strobe marking a new decimated sample from cic_filter.
REQ-005 SHALL have port data_in  input  DW  signed two's-complement sample, qualified by in_valid.
REQ-006 SHALL have port ovr_clr  input  1  clears the sticky overrun flag.
REQ-007 SHALL have port data_out  output  DW  signed compensated sample, held until the next result.
REQ-008 SHALL have port out_valid  output  1  one-cycle strobe on each new data_out.
REQ-009 SHALL have port busy  output  1  high while the FSM is not IDLE.
REQ-010 SHALL have port overrun  output  1  sticky flag for a dropped input sample.

Function
REQ-011 SHALL implement a fixed 7-tap symmetric FIR with coefficients c[0..6] = -1, 0, 9, 16, 9, 0, -1; the sum is 32, so DC gain is 1 after the shift.
REQ-012 SHALL hold a 7-entry signed delay line tap[0..6], where tap[0] is the newest sample.
REQ-013 SHALL use FSM states IDLE, MAC and ROUND.
REQ-014 IDLE with in_valid=1 at edge E0: shift data_in into tap[0], clear acc, set idx=0, go to MAC.
REQ-015 MAC at each edge: acc += c[idx]*tap[idx], idx++; after the edge with idx=6 (E7), go to ROUND.
REQ-016 ROUND at edge E8: data_out <= sat(floor((acc+16)/32)), out_valid <= 1, go to IDLE.
REQ-017 Latency SHALL be 8 clocks from the accepting edge to out_valid, and the minimum accepted input spacing SHALL be 9 clocks.
REQ-018 The accumulator SHALL be DW+8 bits signed, and no intermediate overflow is permitted.
REQ-019 sat() SHALL clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-020 The shift SHALL be arithmetic, with rounding half toward +infinity.
REQ-021 in_valid=1 while busy SHALL drop the sample and leave the delay line and acc untouched.
REQ-022 A dropped sample SHALL set overrun=1 at the next edge.
REQ-023 ovr_clr=1 SHALL clear overrun; when a drop and ovr_clr coincide, set wins.
REQ-024 out_valid SHALL be exactly one cycle wide.
REQ-025 data_out SHALL hold its value while out_valid=0.

Reset
REQ-026 reset=1 at an edge SHALL force: state=IDLE, tap[0..6]=0, acc=0, idx=0, data_out=0, out_valid=0, busy=0, overrun=0.
REQ-027 Reset SHALL override all other inputs, including in_valid.
REQ-028 Reset asserted during MAC or ROUND SHALL abort the computation with no out_valid.

Structure
REQ-029 Package cic_comp_pkg SHALL hold NTAPS=7, the COEF array, SHIFT=5, the accumulator width offset (8), and the state enum type.
REQ-030 Rounding and saturation SHALL live in combinational sub-module cic_comp_rndsat (acc in, DW out).
REQ-031 The delay line, MAC and FSM SHALL live in cic_comp_fir.

Verification
REQ-032 Impulse: data_in=1000 once, then 0s at 9-clock spacing -> data_out = -31, 0, 281, 500, 281, 0, -31, then 0.
REQ-033 DC: constant 1000 at 9-clock spacing -> data_out = 1000 from the 7th output onward.
REQ-034 Saturation: inputs -32768, 32767 x5, -32768 -> 7th output = 32767, with no wrap.
REQ-035 Overrun: in_valid at E0 and E3 -> a single out_valid at E8 and overrun=1 after E4; ovr_clr at E10 -> overrun=0.
REQ-036 Reset mid-operation: reset at E4 after an accept -> no out_valid, data_out=0, busy=0; the next impulse response matches REQ-032.
REQ-037 Back-to-back: in_valid every 9 clocks for 100 samples -> 100 out_valid pulses, overrun stays 0.
